// File: rtl/mem_access_stage_if.sv
`default_nettype none
// EX->MEM->WB bus for the MIPS memory-access stage.
// master = EXECUTE/debug side, slave = the MEM stage.
interface mem_access_stage_if #(
  parameter int NB      = 32,
  parameter int NB_ADDR = 8,
  parameter int NB_REG  = 5
);
  logic                i_step;
  logic                i_flush;
  logic [NB-1:0]       i_alu_result;
  logic [NB-1:0]       i_data_b;
  logic                i_mem_read;
  logic                i_mem_write;
  logic [1:0]          i_width;
  logic                i_unsigned;
  logic                i_reg_write;
  logic                i_mem_to_reg;
  logic [NB_REG-1:0]   i_rd_addr;
  logic [NB_ADDR-1:0]  i_debug_addr;

  logic [NB-1:0]       o_load_data;
  logic [NB-1:0]       o_alu_result;
  logic [NB_REG-1:0]   o_rd_addr;
  logic                o_reg_write;
  logic                o_mem_to_reg;
  logic                o_misaligned;
  logic [NB-1:0]       o_debug_data;

  modport master (
    output i_step, i_flush, i_alu_result, i_data_b, i_mem_read, i_mem_write,
           i_width, i_unsigned, i_reg_write, i_mem_to_reg, i_rd_addr, i_debug_addr,
    input  o_load_data, o_alu_result, o_rd_addr, o_reg_write, o_mem_to_reg,
           o_misaligned, o_debug_data
  );

  modport slave (
    input  i_step, i_flush, i_alu_result, i_data_b, i_mem_read, i_mem_write,
           i_width, i_unsigned, i_reg_write, i_mem_to_reg, i_rd_addr, i_debug_addr,
    output o_load_data, o_alu_result, o_rd_addr, o_reg_write, o_mem_to_reg,
           o_misaligned, o_debug_data
  );
endinterface
`default_nettype wire

// File: rtl/mem_access_stage.sv
`default_nettype none
// MEM stage: word-organised data memory with little-endian byte/half/word
// access, registered MEM/WB outputs and a combinational debug read port.
module mem_access_stage #(
  parameter int NB      = 32,
  parameter int NB_ADDR = 8,
  parameter int NB_REG  = 5
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  mem_access_stage_if.slave  bus
);
  localparam int DEPTH     = 1 << NB_ADDR;
  localparam int NUM_LANES = NB / 8;

  localparam logic [1:0] WIDTH_BYTE = 2'b00;
  localparam logic [1:0] WIDTH_HALF = 2'b01;

  logic [NB-1:0]        mem [DEPTH];

  logic [NB_ADDR-1:0]   word_idx;
  logic [1:0]           lane;
  logic [NB-1:0]        rd_word;
  logic                 misaligned;
  logic [7:0]           byte_val;
  logic [15:0]          half_val;
  logic [NB-1:0]        load_ext;
  logic [NB-1:0]        wr_data;
  logic [NUM_LANES-1:0] byte_en;
  logic                 commit;
  logic                 store_en;

  logic [NB-1:0]        load_data_q;
  logic [NB-1:0]        alu_result_q;
  logic [NB_REG-1:0]    rd_addr_q;
  logic                 reg_write_q;
  logic                 mem_to_reg_q;
  logic                 misaligned_q;

  assign word_idx = bus.i_alu_result[NB_ADDR+1:2];
  assign lane     = bus.i_alu_result[1:0];
  assign rd_word  = mem[word_idx];
  assign byte_val = rd_word[8*lane +: 8];
  assign half_val = rd_word[16*lane[1] +: 16];

  always_comb begin
    misaligned = 1'b0;
    case (bus.i_width)
      WIDTH_BYTE: misaligned = 1'b0;
      WIDTH_HALF: misaligned = lane[0];
      default:    misaligned = (lane != 2'b00);
    endcase
  end

  always_comb begin
    load_ext = '0;
    case (bus.i_width)
      WIDTH_BYTE: load_ext = bus.i_unsigned ? {{(NB-8){1'b0}}, byte_val}
                                            : {{(NB-8){byte_val[7]}}, byte_val};
      WIDTH_HALF: load_ext = bus.i_unsigned ? {{(NB-16){1'b0}}, half_val}
                                            : {{(NB-16){half_val[15]}}, half_val};
      default:    load_ext = rd_word;
    endcase
  end

  // Store data is replicated across lanes; byte_en picks which lanes land.
  always_comb begin
    byte_en = '0;
    wr_data = bus.i_data_b;
    case (bus.i_width)
      WIDTH_BYTE: begin
        wr_data       = {NUM_LANES{bus.i_data_b[7:0]}};
        byte_en[lane] = 1'b1;
      end
      WIDTH_HALF: begin
        wr_data                  = {(NUM_LANES/2){bus.i_data_b[15:0]}};
        byte_en[{lane[1], 1'b0}] = 1'b1;
        byte_en[{lane[1], 1'b1}] = 1'b1;
      end
      default: byte_en = '1;
    endcase
  end

  assign commit   = bus.i_step & ~bus.i_flush;
  // An edge seen while reset is low must not write memory.
  assign store_en = i_reset_n & commit & bus.i_mem_write & ~misaligned;

  always_ff @(posedge i_clk) begin
    if (store_en) begin
      for (int k = 0; k < NUM_LANES; k++) begin
        if (byte_en[k]) begin
          mem[word_idx][8*k +: 8] <= wr_data[8*k +: 8];
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      load_data_q  <= '0;
      alu_result_q <= '0;
      rd_addr_q    <= '0;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      misaligned_q <= 1'b0;
    end else if (bus.i_step) begin
      if (bus.i_flush) begin
        load_data_q  <= '0;
        alu_result_q <= '0;
        rd_addr_q    <= '0;
        reg_write_q  <= 1'b0;
        mem_to_reg_q <= 1'b0;
        misaligned_q <= 1'b0;
      end else begin
        load_data_q  <= (bus.i_mem_read && !misaligned) ? load_ext : '0;
        alu_result_q <= bus.i_alu_result;
        rd_addr_q    <= bus.i_rd_addr;
        reg_write_q  <= bus.i_reg_write & ~(bus.i_mem_read & misaligned);
        mem_to_reg_q <= bus.i_mem_to_reg;
        misaligned_q <= (bus.i_mem_read | bus.i_mem_write) & misaligned;
      end
    end
  end

  assign bus.o_load_data  = load_data_q;
  assign bus.o_alu_result = alu_result_q;
  assign bus.o_rd_addr    = rd_addr_q;
  assign bus.o_reg_write  = reg_write_q;
  assign bus.o_mem_to_reg = mem_to_reg_q;
  assign bus.o_misaligned = misaligned_q;
  assign bus.o_debug_data = mem[bus.i_debug_addr];

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// Bench for mem_access_stage: byte-addressed reference model plus
// hand-computed expectations for the key load/store cases.
module tb_mem_access_stage;
  localparam int NB      = 32;
  localparam int NB_ADDR = 8;
  localparam int NB_REG  = 5;
  localparam int DEPTH   = 1 << NB_ADDR;
  localparam int NBYTES  = 4 * DEPTH;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  mem_access_stage_if #(.NB(NB), .NB_ADDR(NB_ADDR), .NB_REG(NB_REG)) bus ();

  mem_access_stage #(.NB(NB), .NB_ADDR(NB_ADDR), .NB_REG(NB_REG)) dut (
    .i_clk     (clk),
    .i_reset_n (reset_n),
    .bus       (bus)
  );

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;
  bit dbg_en = 1'b0;

  logic [7:0]        mb [NBYTES];
  logic [31:0]       exp_load, exp_alu;
  logic [NB_REG-1:0] exp_rd;
  logic              exp_regw, exp_m2r, exp_mis;

  function automatic logic [31:0] model_word(input int w);
    return {mb[4*w+3], mb[4*w+2], mb[4*w+1], mb[4*w]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, want, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("load_data",  bus.o_load_data,  exp_load);
      chk("alu_result", bus.o_alu_result, exp_alu);
      chk("rd_addr",    32'(bus.o_rd_addr), 32'(exp_rd));
      chk("reg_write",  32'(bus.o_reg_write), 32'(exp_regw));
      chk("mem_to_reg", 32'(bus.o_mem_to_reg), 32'(exp_m2r));
      chk("misaligned", 32'(bus.o_misaligned), 32'(exp_mis));
      if (dbg_en) chk("debug_data", bus.o_debug_data, model_word(int'(bus.i_debug_addr)));
    end
  end

  task automatic set_exp_zero();
    exp_load = '0; exp_alu = '0; exp_rd = '0;
    exp_regw = 1'b0; exp_m2r = 1'b0; exp_mis = 1'b0;
  endtask

  // One pipeline cycle: drive at negedge+1, model the edge, return at next negedge+1.
  task automatic cyc(input bit step, input bit flush, input bit rd, input bit wr,
                     input logic [1:0] width, input bit uns, input bit regw, input bit m2r,
                     input logic [31:0] alu, input logic [31:0] db,
                     input logic [NB_REG-1:0] rdaddr, input logic [NB_ADDR-1:0] dbg);
    int          a, size;
    bit          mis;
    logic [31:0] val;
    logic [31:0] n_load, n_alu;
    logic [NB_REG-1:0] n_rd;
    logic        n_regw, n_m2r, n_mis;
    bus.i_step = step; bus.i_flush = flush; bus.i_mem_read = rd; bus.i_mem_write = wr;
    bus.i_width = width; bus.i_unsigned = uns; bus.i_reg_write = regw;
    bus.i_mem_to_reg = m2r; bus.i_alu_result = alu; bus.i_data_b = db;
    bus.i_rd_addr = rdaddr; bus.i_debug_addr = dbg;

    a    = int'(alu % NBYTES);
    size = (width == 2'b00) ? 1 : (width == 2'b01) ? 2 : 4;
    mis  = (a % size) != 0;
    val  = '0;
    if (!mis) begin
      for (int k = 0; k < size; k++) val = val | (32'(mb[a+k]) << (8*k));
      if (size < 4 && !uns && val[8*size-1]) val = val | (32'hFFFF_FFFF << (8*size));
    end
    n_load = exp_load; n_alu = exp_alu; n_rd = exp_rd;
    n_regw = exp_regw; n_m2r = exp_m2r; n_mis = exp_mis;
    if (step && flush) begin
      n_load = '0; n_alu = '0; n_rd = '0; n_regw = 0; n_m2r = 0; n_mis = 0;
    end else if (step) begin
      n_load = (rd && !mis) ? val : 32'h0;
      n_alu  = alu;
      n_rd   = rdaddr;
      n_regw = regw && !(rd && mis);
      n_m2r  = m2r;
      n_mis  = (rd || wr) && mis;
    end

    @(posedge clk);
    #1;
    exp_load = n_load; exp_alu = n_alu; exp_rd = n_rd;
    exp_regw = n_regw; exp_m2r = n_m2r; exp_mis = n_mis;
    if (step && !flush && wr && !mis)
      for (int k = 0; k < size; k++) mb[a+k] = db[8*k +: 8];
    @(negedge clk);
    #1;
  endtask

  task automatic st(input logic [1:0] w, input logic [31:0] a, input logic [31:0] d);
    cyc(1, 0, 0, 1, w, 0, 0, 0, a, d, 5'd0, a[NB_ADDR+1:2]);
  endtask

  task automatic ld(input logic [1:0] w, input bit u, input logic [31:0] a, input logic [NB_REG-1:0] r);
    cyc(1, 0, 1, 0, w, u, 1, 1, a, 32'h0, r, a[NB_ADDR+1:2]);
  endtask

  task automatic reset_mid_store(input logic [31:0] a, input logic [31:0] d);
    bus.i_step = 1; bus.i_flush = 0; bus.i_mem_read = 0; bus.i_mem_write = 1;
    bus.i_width = 2'b11; bus.i_unsigned = 0; bus.i_reg_write = 1; bus.i_mem_to_reg = 1;
    bus.i_alu_result = a; bus.i_data_b = d; bus.i_rd_addr = 5'd7;
    bus.i_debug_addr = a[NB_ADDR+1:2];
    #2;
    reset_n = 1'b0;
    set_exp_zero();
    #1;
    chk("rst_async_load", bus.o_load_data, 32'h0);
    chk("rst_async_alu",  bus.o_alu_result, 32'h0);
    chk("rst_async_regw", 32'(bus.o_reg_write), 32'h0);
    chk("rst_async_mis",  32'(bus.o_misaligned), 32'h0);
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    bus.i_step = 0; bus.i_mem_write = 0;
    @(negedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < NBYTES; i++) mb[i] = 8'h00;
    set_exp_zero();
    bus.i_step = 0; bus.i_flush = 0; bus.i_mem_read = 0; bus.i_mem_write = 0;
    bus.i_width = 2'b11; bus.i_unsigned = 0; bus.i_reg_write = 0; bus.i_mem_to_reg = 0;
    bus.i_alu_result = '0; bus.i_data_b = '0; bus.i_rd_addr = '0; bus.i_debug_addr = '0;
    repeat (2) @(negedge clk);
    #1;
    reset_n = 1'b1;
    chk("reset_load", bus.o_load_data, 32'h0);
    chk("reset_regw", 32'(bus.o_reg_write), 32'h0);
    cmp_en = 1'b1;

    // Known contents: word i = i replicated in every byte.
    for (int i = 0; i < DEPTH; i++) st(2'b11, 32'(4*i), 32'(i) * 32'h0101_0101);
    dbg_en = 1'b1;

    reset_mid_store(32'h14, 32'hFFFF_FFFF);
    chk("rst_no_store", bus.o_debug_data, 32'h0505_0505);

    st(2'b11, 32'h10, 32'hDEAD_BEEF);
    chk("sw_debug", bus.o_debug_data, 32'hDEAD_BEEF);
    ld(2'b11, 0, 32'h10, 5'd3);
    chk("lw_data", bus.o_load_data, 32'hDEAD_BEEF);
    chk("lw_regw", 32'(bus.o_reg_write), 32'h1);

    st(2'b11, 32'h20, 32'h80F1_7F02);
    ld(2'b00, 0, 32'h23, 5'd4);
    chk("lb_23", bus.o_load_data, 32'hFFFF_FF80);
    ld(2'b00, 1, 32'h23, 5'd4);
    chk("lbu_23", bus.o_load_data, 32'h0000_0080);
    ld(2'b01, 0, 32'h20, 5'd5);
    chk("lh_20", bus.o_load_data, 32'h0000_7F02);
    ld(2'b01, 0, 32'h22, 5'd5);
    chk("lh_22", bus.o_load_data, 32'hFFFF_80F1);
    st(2'b00, 32'h21, 32'h0000_00AA);
    chk("sb_21", bus.o_debug_data, 32'h80F1_AA02);

    ld(2'b11, 0, 32'h22, 5'd6);
    chk("mis_lw_flag", 32'(bus.o_misaligned), 32'h1);
    chk("mis_lw_regw", 32'(bus.o_reg_write), 32'h0);
    chk("mis_lw_data", bus.o_load_data, 32'h0);
    st(2'b01, 32'h11, 32'h0000_FFFF);
    chk("mis_sh_flag", 32'(bus.o_misaligned), 32'h1);
    chk("mis_sh_mem", bus.o_debug_data, 32'hDEAD_BEEF);

    st(2'b11, 32'h30, 32'hCAFE_F00D);
    cyc(1, 1, 0, 1, 2'b11, 0, 1, 1, 32'h30, 32'h1111_1111, 5'd7, 8'd12);
    chk("flush_mem", bus.o_debug_data, 32'hCAFE_F00D);
    chk("flush_alu", bus.o_alu_result, 32'h0);
    ld(2'b11, 0, 32'h30, 5'd9);
    cyc(0, 1, 0, 1, 2'b11, 0, 0, 0, 32'h30, 32'h2222_2222, 5'd1, 8'd12);
    chk("hold_load", bus.o_load_data, 32'hCAFE_F00D);
    chk("hold_rd", 32'(bus.o_rd_addr), 32'd9);
    chk("hold_mem", bus.o_debug_data, 32'hCAFE_F00D);

    st(2'b11, (32'd4 << (NB_ADDR + 2)) + 32'd8, 32'h1234_5678);
    chk("wrap_debug", bus.o_debug_data, 32'h1234_5678);
    cyc(1, 0, 1, 1, 2'b11, 0, 1, 1, 32'h8, 32'h0, 5'd3, 8'd2);
    chk("rbw_load", bus.o_load_data, 32'h1234_5678);
    chk("rbw_debug", bus.o_debug_data, 32'h0);

    st(2'b01, 32'h42, 32'h1234_BEEF);
    ld(2'b01, 0, 32'h42, 5'd10);
    chk("lh_42", bus.o_load_data, 32'hFFFF_BEEF);
    ld(2'b00, 1, 32'h43, 5'd11);
    ld(2'b11, 0, 32'h40, 5'd12);
    st(2'b00, 32'h3FF, 32'h0000_0077);
    ld(2'b00, 0, 32'h3FF, 5'd13);
    ld(2'b01, 1, 32'h3FE, 5'd14);
    cyc(1, 0, 0, 0, 2'b10, 0, 1, 0, 32'h0000_0ABC, 32'h0, 5'd15, 8'd0);

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
